// File: rtl/sram_audio_arbiter.sv
// Shares one 256Kx16 async SRAM between FIFO-buffered record writes and single outstanding playback reads.
// Writes take WR_CYCLES+2 cycles; an idle read returns in RD_CYCLES+2 cycles; bus turnaround always passes IDLE.
module sram_audio_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_CYCLES  = 2,
  parameter int RD_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [17:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_full,
  output logic        wr_overflow,
  input  logic        rd_req,
  input  logic [17:0] rd_addr,
  output logic        rd_busy,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic [17:0] last_addr,
  input  logic        clr_last,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 8;
  localparam int WR_M1 = WR_CYCLES - 1;
  localparam int RD_M1 = RD_CYCLES - 1;
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] WR_LAST  = WR_M1[CW-1:0];
  localparam logic [CW-1:0] RD_LAST  = RD_M1[CW-1:0];

  typedef enum logic [1:0] {S_IDLE, S_WR_ACT, S_WR_REC, S_RD_ACT} state_t;

  state_t        r_state, w_state_nxt;
  logic [17:0]   r_fifo_addr [FIFO_DEPTH];
  logic [15:0]   r_fifo_data [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_full, r_overflow;
  logic          w_push, w_pop;
  logic [17:0]   r_wr_addr, r_rd_addr, r_last;
  logic [15:0]   r_wr_data, r_rd_data;
  logic          r_rd_busy, r_rd_valid;
  logic [CW-1:0] r_cnt;
  logic          w_rd_last, w_wr_done;
  logic          w_ce_n, w_oe_n, w_we_n, w_be_n, w_dq_oe;
  logic [17:0]   w_sram_addr;

  assign w_push = wr_req && !r_full;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= wr_addr;
      r_fifo_data[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr    <= r_rptr + 1'b1;
        r_wr_addr <= r_fifo_addr[r_rptr];
        r_wr_data <= r_fifo_data[r_rptr];
      end
    end
  end

  // A full FIFO outranks a pending read so the codec never loses samples to playback.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_ce_n      = 1'b1;
    w_oe_n      = 1'b1;
    w_we_n      = 1'b1;
    w_be_n      = 1'b1;
    w_dq_oe     = 1'b0;
    w_sram_addr = '0;
    case (r_state)
      S_IDLE: begin
        if (r_full) begin
          w_state_nxt = S_WR_ACT;
          w_pop       = 1'b1;
        end else if (r_rd_busy) begin
          w_state_nxt = S_RD_ACT;
        end else if (r_count != '0) begin
          w_state_nxt = S_WR_ACT;
          w_pop       = 1'b1;
        end
      end
      S_WR_ACT: begin
        w_ce_n      = 1'b0;
        w_we_n      = 1'b0;
        w_be_n      = 1'b0;
        w_dq_oe     = 1'b1;
        w_sram_addr = r_wr_addr;
        if (r_cnt == WR_LAST) w_state_nxt = S_WR_REC;
      end
      S_WR_REC: begin
        w_ce_n      = 1'b0;
        w_be_n      = 1'b0;
        w_dq_oe     = 1'b1;
        w_sram_addr = r_wr_addr;
        w_state_nxt = S_IDLE;
      end
      S_RD_ACT: begin
        w_ce_n      = 1'b0;
        w_oe_n      = 1'b0;
        w_be_n      = 1'b0;
        w_sram_addr = r_rd_addr;
        if (r_cnt == RD_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rd_last = (r_state == S_RD_ACT) && (r_cnt == RD_LAST);
  assign w_wr_done = (r_state == S_WR_REC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_busy  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_addr  <= '0;
    end else begin
      r_rd_valid <= w_rd_last;
      if (w_rd_last) begin
        r_rd_data <= SRAM_DQ;
        r_rd_busy <= 1'b0;
      end else if (rd_req && !r_rd_busy) begin
        r_rd_addr <= rd_addr;
        r_rd_busy <= 1'b1;
      end
    end
  end

  // A completing write coincident with clr_last restarts tracking from that address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_done) begin
        if (clr_last)                r_last <= r_wr_addr;
        else if (r_wr_addr > r_last) r_last <= r_wr_addr;
      end else if (clr_last) begin
        r_last <= '0;
      end
      if (wr_req && r_full) r_overflow <= 1'b1;
      else if (clr_last)    r_overflow <= 1'b0;
    end
  end

  assign SRAM_DQ     = w_dq_oe ? r_wr_data : 16'bz;
  assign SRAM_ADDR   = w_sram_addr;
  assign SRAM_CE_N   = w_ce_n;
  assign SRAM_OE_N   = w_oe_n;
  assign SRAM_WE_N   = w_we_n;
  assign SRAM_UB_N   = w_be_n;
  assign SRAM_LB_N   = w_be_n;
  assign wr_full     = r_full;
  assign wr_overflow = r_overflow;
  assign rd_busy     = r_rd_busy;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign last_addr   = r_last;

endmodule

// File: tb/tb_sram_audio_arbiter.sv
// Directed bench for sram_audio_arbiter with a behavioural async SRAM on a pulled-up data bus.
// Released bus reads 16'hFFFF, so no test sample uses that value.
module tb_sram_audio_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0, clr_last = 1'b0;
  logic [17:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  wire         wr_full, wr_overflow, rd_busy, rd_valid;
  wire  [15:0] rd_data;
  wire  [17:0] last_addr, SRAM_ADDR;
  tri1  [15:0] SRAM_DQ;
  wire         SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  sram_audio_arbiter dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_full(wr_full), .wr_overflow(wr_overflow),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .last_addr(last_addr), .clr_last(clr_last),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:262143];
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'bz;

  int checks = 0;
  int errors = 0;

  logic [17:0] wr_log_addr [$];
  logic [15:0] wr_log_data [$];
  logic [19:0] op_log [$];
  logic        prev_we = 1'b1, prev_oe = 1'b1;
  int          we_run = 0, last_we_len = 0;
  int          viol = 0, rd_cnt = 0, rd_bad = 0;
  logic [15:0] exp_rd = '0;

  always @(negedge clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
    if (!SRAM_WE_N && prev_we) begin
      wr_log_addr.push_back(SRAM_ADDR);
      wr_log_data.push_back(SRAM_DQ);
      op_log.push_back({2'b01, SRAM_ADDR});
    end
    if (!SRAM_OE_N && prev_oe) begin
      op_log.push_back({2'b10, SRAM_ADDR});
      exp_rd <= mem[SRAM_ADDR];
    end
    if (!SRAM_WE_N) we_run <= we_run + 1;
    else if (!prev_we) begin
      last_we_len <= we_run;
      we_run      <= 0;
    end
    if ((!SRAM_OE_N && (!SRAM_WE_N || SRAM_DQ != mem[SRAM_ADDR])) ||
        (SRAM_CE_N && SRAM_DQ != 16'hFFFF))
      viol <= viol + 1;
    if (rd_valid) begin
      rd_cnt <= rd_cnt + 1;
      if (rd_data != exp_rd) rd_bad <= rd_bad + 1;
    end
    prev_we <= SRAM_WE_N;
    prev_oe <= SRAM_OE_N;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [17:0] a, input logic [15:0] d);
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic wait_rd(output int cyc, output logic [15:0] dat);
    cyc = 0;
    dat = '0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (rd_valid) begin
        dat = rd_data;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int          cyc, nwr, rd0, wr0, acc_wr, acc_rd;
    logic [15:0] dat;
    for (int i = 0; i < 262144; i++) mem[i] <= 16'(i) ^ 16'h5A5A;

    #1 rst = 1'b1;
    #2;
    chk("rst_wr_full", wr_full, 0);
    chk("rst_overflow", wr_overflow, 0);
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_last", last_addr, 0);
    chk("rst_ctl", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1F);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_dq", SRAM_DQ, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // single write then read back
    wr1(18'h00010, 16'hA5C3);
    repeat (8) tick();
    chk("w1_count", wr_log_addr.size(), 1);
    chk("w1_addr", wr_log_addr[0], 18'h00010);
    chk("w1_data", wr_log_data[0], 16'hA5C3);
    chk("w1_we_len", last_we_len, 2);
    chk("w1_last", last_addr, 18'h00010);
    rd_addr = 18'h00010; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("r1_busy", rd_busy, 1);
    wait_rd(cyc, dat);
    chk("r1_latency", cyc, 4);
    chk("r1_data", dat, 16'hA5C3);
    @(negedge clk);
    chk("r1_pulse", rd_valid, 0);
    chk("r1_idle", rd_busy, 0);

    // six back-to-back writes: one drains early, the sixth meets a full FIFO
    wr_log_addr.delete(); wr_log_data.delete();
    tick();
    for (int k = 0; k < 6; k++) begin
      wr_addr = 18'h00100 + 18'(k); wr_data = 16'hB000 + 16'(k); wr_req = 1'b1;
      tick();
      if (k == 4) chk("ov_full", wr_full, 1);
    end
    wr_req = 1'b0;
    chk("ov_sticky", wr_overflow, 1);
    repeat (30) tick();
    chk("ov_count", wr_log_addr.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("ov_addr", wr_log_addr[i], 18'h00100 + 18'(i));
      chk("ov_data", wr_log_data[i], 16'hB000 + 16'(i));
    end
    chk("ov_drained", wr_full, 0);
    chk("ov_last", last_addr, 18'h00104);
    clr_last = 1'b1;
    tick();
    clr_last = 1'b0;
    chk("ov_clr", wr_overflow, 0);
    chk("ov_clr_last", last_addr, 0);

    // two queued writes, read pending: read wins, no forwarding
    op_log.delete();
    wr1(18'h00200, 16'hC000);
    wr1(18'h00201, 16'hC001);
    wr_addr = 18'h00202; wr_data = 16'hC002; wr_req = 1'b1;
    rd_addr = 18'h00201; rd_req = 1'b1;
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    wait_rd(cyc, dat);
    chk("a1_seen", cyc < 20, 1);
    chk("a1_data", dat, 16'h0201 ^ 16'h5A5A);
    repeat (20) tick();
    chk("a1_ops", op_log.size(), 4);
    chk("a1_op0", op_log[0], {2'b01, 18'h00200});
    chk("a1_op1", op_log[1], {2'b10, 18'h00201});
    chk("a1_op2", op_log[2], {2'b01, 18'h00201});
    chk("a1_op3", op_log[3], {2'b01, 18'h00202});

    // FIFO full when the read is pending: one write goes first
    op_log.delete();
    for (int k = 0; k < 5; k++) begin
      wr_addr = 18'h00300 + 18'(k); wr_data = 16'hD000 + 16'(k); wr_req = 1'b1;
      if (k == 3) begin rd_addr = 18'h00300; rd_req = 1'b1; end
      tick();
      rd_req = 1'b0;
    end
    wr_req = 1'b0;
    wait_rd(cyc, dat);
    chk("a2_seen", cyc < 20, 1);
    chk("a2_data", dat, 16'hD000);
    repeat (40) tick();
    chk("a2_ops", op_log.size(), 6);
    chk("a2_op0", op_log[0], {2'b01, 18'h00300});
    chk("a2_op1", op_log[1], {2'b01, 18'h00301});
    chk("a2_op2", op_log[2], {2'b10, 18'h00300});
    chk("a2_op3", op_log[3], {2'b01, 18'h00302});
    chk("a2_op5", op_log[5], {2'b01, 18'h00304});

    // unsigned max tracking and clr_last coincident with completion
    clr_last = 1'b1;
    tick();
    clr_last = 1'b0;
    wr1(18'h3FFFF, 16'h1111);
    repeat (8) tick();
    chk("max_top", last_addr, 18'h3FFFF);
    wr1(18'h00005, 16'h5555);
    repeat (8) tick();
    chk("max_keep", last_addr, 18'h3FFFF);
    wr1(18'h00020, 16'h2222);
    repeat (3) tick();
    chk("rec_ctl", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b011);
    chk("rec_addr", SRAM_ADDR, 18'h00020);
    chk("rec_dq", SRAM_DQ, 16'h2222);
    clr_last = 1'b1;
    tick();
    clr_last = 1'b0;
    chk("clr_coinc", last_addr, 18'h00020);
    repeat (4) tick();

    // reset in the middle of a write
    nwr = wr_log_addr.size();
    wr1(18'h00040, 16'h3333);
    tick();
    chk("mid_we_low", SRAM_WE_N, 0);
    #1 rst = 1'b1;
    #1;
    chk("mid_we", SRAM_WE_N, 1);
    chk("mid_ce", SRAM_CE_N, 1);
    chk("mid_dq", SRAM_DQ, 16'hFFFF);
    chk("mid_full", wr_full, 0);
    chk("mid_last", last_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) tick();
    chk("mid_no_retry", wr_log_addr.size(), nwr);

    // random mix
    rd0 = rd_cnt;
    wr0 = wr_log_addr.size();
    acc_wr = 0;
    acc_rd = 0;
    for (int c = 0; c < 10000; c++) begin
      wr_req  = ($urandom_range(3) == 0);
      wr_addr = 18'($urandom_range(63));
      wr_data = 16'($urandom_range(16'hFFFE));
      rd_req  = ($urandom_range(2) == 0);
      rd_addr = 18'($urandom_range(63));
      if (wr_req && !wr_full) acc_wr++;
      if (rd_req && !rd_busy) acc_rd++;
      tick();
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (40) tick();
    chk("rnd_reads", rd_cnt - rd0, acc_rd);
    chk("rnd_writes", wr_log_addr.size() - wr0, acc_wr);
    chk("rnd_rd_data", rd_bad, 0);
    chk("bus_contention", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
